// File: rtl/fifo_rd_serializer.sv
// Pops words from a synchronous FIFO and transmits each one as a UART-style
// frame: start bit, WIDTH data bits LSB-first, then STOP_BITS stop bits.
module fifo_rd_serializer #(
  parameter int WIDTH        = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_valid,
  input  logic             fifo_under,
  output logic             fifo_re,
  output logic             txd,
  output logic             busy,
  output logic [15:0]      word_cnt,
  output logic             err
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    START,
    DATA,
    STOP
  } state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   shift_reg;
  logic [BAUD_W-1:0]  baud_reg;
  logic [BIT_W-1:0]   bit_reg;
  logic               wait_reg;
  logic               fifo_re_reg;
  logic               txd_reg;
  logic [15:0]        word_cnt_reg;
  logic               err_reg;
  logic               baud_tick;

  assign baud_tick = (baud_reg == BAUD_LAST);

  assign fifo_re  = fifo_re_reg;
  assign txd      = txd_reg;
  assign busy     = (state_reg != IDLE);
  assign word_cnt = word_cnt_reg;
  assign err      = err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      baud_reg     <= '0;
      bit_reg      <= '0;
      wait_reg     <= 1'b0;
      fifo_re_reg  <= 1'b0;
      txd_reg      <= 1'b1;
      word_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          txd_reg <= 1'b1;
          if (en && !fifo_empty) begin
            fifo_re_reg <= 1'b1;
            state_reg   <= REQ;
          end
        end
        REQ: begin
          fifo_re_reg <= 1'b0;
          wait_reg    <= 1'b0;
          state_reg   <= WAIT;
        end
        WAIT: begin
          // Data is captured here, so later changes on fifo_dout cannot corrupt the frame.
          if (fifo_valid) begin
            shift_reg <= fifo_dout;
            txd_reg   <= 1'b0;
            baud_reg  <= '0;
            wait_reg  <= 1'b0;
            state_reg <= START;
          end else if (fifo_under || wait_reg) begin
            err_reg   <= 1'b1;
            wait_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            wait_reg <= 1'b1;
          end
        end
        START: begin
          if (baud_tick) begin
            baud_reg  <= '0;
            bit_reg   <= '0;
            txd_reg   <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state_reg <= DATA;
          end else begin
            baud_reg <= baud_reg + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_tick) begin
            baud_reg <= '0;
            if (bit_reg == DATA_LAST) begin
              bit_reg   <= '0;
              txd_reg   <= 1'b1;
              state_reg <= STOP;
            end else begin
              bit_reg   <= bit_reg + BIT_W'(1);
              txd_reg   <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            baud_reg <= baud_reg + BAUD_W'(1);
          end
        end
        STOP: begin
          // bit_reg is reused to count stop bits so the baud counter stays narrow.
          if (baud_tick) begin
            baud_reg <= '0;
            if (bit_reg == STOP_LAST) begin
              bit_reg      <= '0;
              word_cnt_reg <= word_cnt_reg + 16'd1;
              state_reg    <= IDLE;
            end else begin
              bit_reg <= bit_reg + BIT_W'(1);
            end
          end else begin
            baud_reg <= baud_reg + BAUD_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Directed bench for fifo_rd_serializer: a small FIFO stand-in feeds words and
// each serial frame is sampled cycle by cycle and decoded.
module tb_fifo_rd_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        fifo_empty;
  logic [15:0] fifo_dout;
  logic        fifo_valid;
  logic        fifo_under;
  logic        fifo_re;
  logic        txd;
  logic        busy;
  logic [15:0] word_cnt;
  logic        err;

  int tests = 0;
  int fails = 0;

  fifo_rd_serializer #(.WIDTH(16), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_valid(fifo_valid),
    .fifo_under(fifo_under),
    .fifo_re   (fifo_re),
    .txd       (txd),
    .busy      (busy),
    .word_cnt  (word_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  // FIFO stand-in: one-cycle read latency, random dout when not popping
  logic [15:0] mem [0:15];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        force_nonempty = 1'b0;
  logic        under_en = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr) && !force_nonempty;

  initial begin
    fifo_valid = 1'b0;
    fifo_under = 1'b0;
    fifo_dout  = 16'h0;
  end

  always @(posedge clk) begin
    fifo_valid <= 1'b0;
    fifo_under <= 1'b0;
    fifo_dout  <= 16'($urandom);
    if (fifo_re) begin
      if (rd_ptr != wr_ptr) begin
        fifo_dout  <= mem[rd_ptr % 16];
        fifo_valid <= 1'b1;
        rd_ptr     <= rd_ptr + 1;
      end else if (under_en) begin
        fifo_under <= 1'b1;
      end
    end
  end

  int re_cnt = 0;
  int txd_low_cnt = 0;
  always @(negedge clk) begin
    if (fifo_re) re_cnt <= re_cnt + 1;
    if (txd === 1'b0) txd_low_cnt <= txd_low_cnt + 1;
  end

  task automatic push(input logic [15:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits for the start bit, then samples all 72 frame cycles and decodes them.
  task automatic expect_frame(input string tag, input logic [15:0] exp, output int gap);
    logic [17:0] slots;
    logic        steady;
    int          n;
    slots  = '0;
    steady = 1'b1;
    gap    = 0;
    n      = 0;
    while (n < 400) begin
      @(negedge clk);
      if (txd === 1'b0) break;
      gap++;
      n++;
    end
    check({tag, "_start_timeout"}, 32'(n >= 400), 32'd0);
    for (int s = 0; s < 18; s++) begin
      for (int c = 0; c < 4; c++) begin
        if (!(s == 0 && c == 0)) @(negedge clk);
        if (c == 0) slots[s] = txd;
        else if (txd !== slots[s]) steady = 1'b0;
      end
    end
    check({tag, "_startbit"}, 32'(slots[0]), 32'd0);
    check({tag, "_data"}, 32'(slots[16:1]), 32'(exp));
    check({tag, "_stopbit"}, 32'(slots[17]), 32'd1);
    check({tag, "_bit_timing"}, 32'(steady), 32'd1);
    $display("[TB] frame %s decoded %h gap %0d", tag, slots[16:1], gap);
  endtask

  task automatic wait_re(input string tag);
    int n;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (fifo_re === 1'b1) break;
      n++;
    end
    check({tag, "_re_timeout"}, 32'(n >= 50), 32'd0);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (txd === 1'b0) break;
      n++;
    end
    check({tag, "_txd_timeout"}, 32'(n >= 50), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int r0;
    int l0;
    int exp_cnt;
    logic bad;

    // 1: reset, then enabled with empty FIFO
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_fifo_re", 32'(fifo_re), 32'd0);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_re !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check("empty_idle_quiet", 32'(bad), 32'd0);
    check("empty_word_cnt", 32'(word_cnt), 32'd0);
    exp_cnt = 0;

    // 2: single word 0x0001
    r0 = re_cnt;
    push(16'h0001);
    wait_re("t2");
    expect_frame("t2", 16'h0001, gap);
    check("t2_re_to_start_gap", 32'(gap), 32'd1);
    exp_cnt = exp_cnt + 1;
    @(negedge clk);
    check("t2_word_cnt", 32'(word_cnt), 32'(exp_cnt));
    check("t2_busy_after", 32'(busy), 32'd0);
    check("t2_re_pulses", 32'(re_cnt - r0), 32'd1);

    // 3: back-to-back words
    r0 = re_cnt;
    push(16'hA5C3);
    push(16'h8000);
    expect_frame("t3a", 16'hA5C3, gap);
    expect_frame("t3b", 16'h8000, gap);
    check("t3_gap", 32'(gap), 32'd3);
    exp_cnt = exp_cnt + 2;
    @(negedge clk);
    check("t3_word_cnt", 32'(word_cnt), 32'(exp_cnt));
    check("t3_re_pulses", 32'(re_cnt - r0), 32'd2);

    // 4: en drops during data bit 5 with another word waiting
    r0 = re_cnt;
    push(16'h1234);
    push(16'h5678);
    wait_start("t4");
    repeat (26) @(negedge clk);
    en = 1'b0;
    repeat (80) @(negedge clk);
    exp_cnt = exp_cnt + 1;
    check("t4_word_cnt", 32'(word_cnt), 32'(exp_cnt));
    check("t4_re_pulses", 32'(re_cnt - r0), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_txd_idle", 32'(txd), 32'd1);
    en = 1'b1;
    expect_frame("t4_resume", 16'h5678, gap);
    exp_cnt = exp_cnt + 1;
    @(negedge clk);
    check("t4_resume_cnt", 32'(word_cnt), 32'(exp_cnt));

    // 5a: underflow after the pop
    l0 = txd_low_cnt;
    under_en = 1'b1;
    force_nonempty = 1'b1;
    wait_re("t5u");
    en = 1'b0;
    force_nonempty = 1'b0;
    repeat (6) @(negedge clk);
    check("t5u_err", 32'(err), 32'd1);
    check("t5u_busy", 32'(busy), 32'd0);
    check("t5u_no_start", 32'(txd_low_cnt - l0), 32'd0);
    check("t5u_word_cnt", 32'(word_cnt), 32'(exp_cnt));
    under_en = 1'b0;

    // err stays set across a good frame
    en = 1'b1;
    push(16'hC0DE);
    expect_frame("t5_good", 16'hC0DE, gap);
    exp_cnt = exp_cnt + 1;
    @(negedge clk);
    check("t5_err_sticky", 32'(err), 32'd1);
    check("t5_good_cnt", 32'(word_cnt), 32'(exp_cnt));

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    check("t5_err_cleared", 32'(err), 32'd0);
    check("t5_cnt_cleared", 32'(word_cnt), 32'd0);

    // 5b: valid never arrives, no underflow flag
    l0 = txd_low_cnt;
    force_nonempty = 1'b1;
    wait_re("t5s");
    en = 1'b0;
    force_nonempty = 1'b0;
    repeat (6) @(negedge clk);
    check("t5s_err", 32'(err), 32'd1);
    check("t5s_busy", 32'(busy), 32'd0);
    check("t5s_no_start", 32'(txd_low_cnt - l0), 32'd0);

    // 6: reset during data bit 7, next frame must be intact
    en = 1'b1;
    push(16'h00FF);
    push(16'h6B2D);
    wait_start("t6");
    repeat (34) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_txd", 32'(txd), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_word_cnt", 32'(word_cnt), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    check("t6_fifo_re", 32'(fifo_re), 32'd0);
    rst = 1'b0;
    expect_frame("t6_after_rst", 16'h6B2D, gap);
    exp_cnt = exp_cnt + 1;
    @(negedge clk);
    check("t6_after_cnt", 32'(word_cnt), 32'(exp_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
